// File: rtl/mem_port_arbiter_if.sv
// Purpose: bundles the per-core request/grant/return signals and the registered memory port of mem_port_arbiter.
// Latency: none, wires only.
// Backpressure: none; a requester holds req/we/addr/wdata until its gnt bit pulses.
// Ports (slave = arbiter view):
//   req/we/addr/wdata  core -> arbiter   packed per core, core i at [i*W +: W]
//   gnt/rvalid/rdata   arbiter -> core   one-hot grant, one-hot read return, shared read data
//   mem_en/mem_wren/mem_addr/mem_wdata   arbiter -> memory, registered
//   mem_rdata          memory -> arbiter
//   idle               arbiter status
interface mem_port_arbiter_if #(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
);
  logic [N_CORES-1:0]        req;
  logic [N_CORES-1:0]        we;
  logic [N_CORES*ADDR_W-1:0] addr;
  logic [N_CORES*DATA_W-1:0] wdata;
  logic [N_CORES-1:0]        gnt;
  logic [N_CORES-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;
  logic                      mem_en;
  logic                      mem_wren;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [DATA_W-1:0]         mem_rdata;
  logic                      idle;

  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output gnt, rvalid, rdata, mem_en, mem_wren, mem_addr, mem_wdata, idle
  );

  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  gnt, rvalid, rdata, mem_en, mem_wren, mem_addr, mem_wdata, idle
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: round-robin arbiter sharing one single-port memory among N_CORES requesters.
// Latency: grant combinational in cycle t, memory access registered in t+1, read return registered in t+2+RD_LAT.
// Backpressure: a requester waits with req held until gnt; at most one grant per cycle, starvation bounded by N_CORES cycles.
// Ports:
//   clk, reset    clock and asynchronous active-high reset
//   bus (slave)   core request/grant/return and registered memory port, see mem_port_arbiter_if
module mem_port_arbiter #(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int RD_LAT  = 1
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam int ID_W = $clog2(N_CORES);

  // One read-tracker slot: which core a read in the memory pipeline belongs to.
  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } trk_t;

  // Round-robin pointer: the core that gets first look next cycle.
  logic [ID_W-1:0]   ptr;

  logic              gnt_any;
  logic [ID_W-1:0]   gnt_id;
  logic [ID_W:0]     cand_sum;
  logic [ID_W-1:0]   cand;

  logic [ADDR_W-1:0] core_addr  [N_CORES];
  logic [DATA_W-1:0] core_wdata [N_CORES];
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Slot 0 holds a read during its mem_en cycle; slot RD_LAT lines up with valid mem_rdata.
  trk_t [RD_LAT:0]    trk;
  trk_t               trk_in;
  trk_t               trk_out;
  logic               trk_busy;
  logic [N_CORES-1:0] rvalid_nxt;

  // Unpack the per-core buses so the granted core can be selected by index.
  for (genvar i = 0; i < N_CORES; i++) begin : g_unpack
    assign core_addr[i]  = bus.addr[i*ADDR_W +: ADDR_W];
    assign core_wdata[i] = bus.wdata[i*DATA_W +: DATA_W];
  end

  // Search from ptr upwards, wrapping modulo N_CORES; the first requester wins.
  // The sum is one bit wider than the pointer so the wrap works for any N_CORES.
  // Grants are suppressed while reset is asserted.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_id   = '0;
    cand_sum = '0;
    cand     = '0;
    if (!reset) begin
      for (int k = 0; k < N_CORES; k++) begin
        cand_sum = {1'b0, ptr} + (ID_W+1)'(k);
        if (cand_sum >= (ID_W+1)'(N_CORES)) begin
          cand_sum = cand_sum - (ID_W+1)'(N_CORES);
        end
        cand = cand_sum[ID_W-1:0];
        if (!gnt_any && bus.req[cand]) begin
          gnt_any = 1'b1;
          gnt_id  = cand;
        end
      end
    end
  end

  always_comb begin
    bus.gnt = '0;
    if (gnt_any) begin
      bus.gnt[gnt_id] = 1'b1;
    end
  end

  always_comb begin
    sel_we    = bus.we[gnt_id];
    sel_addr  = core_addr[gnt_id];
    sel_wdata = core_wdata[gnt_id];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= (gnt_id == ID_W'(N_CORES - 1)) ? '0 : gnt_id + ID_W'(1);
    end
  end

  // Issue stage. Address and write data hold between accesses so the memory
  // port only toggles on real traffic; write data only moves on writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.mem_en    <= 1'b0;
      bus.mem_wren  <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.mem_en   <= gnt_any;
      bus.mem_wren <= gnt_any & sel_we;
      if (gnt_any) begin
        bus.mem_addr <= sel_addr;
        if (sel_we) begin
          bus.mem_wdata <= sel_wdata;
        end
      end
    end
  end

  // Only reads enter the tracker; writes get no acknowledge.
  always_comb begin
    trk_in.vld = gnt_any & ~sel_we;
    trk_in.id  = gnt_id;
    trk_out    = trk[RD_LAT];
  end

  // Reset flushes the tracker, so reads in flight at reset never return.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trk <= '0;
    end else begin
      trk <= {trk[RD_LAT-1:0], trk_in};
    end
  end

  always_comb begin
    trk_busy = 1'b0;
    for (int k = 0; k <= RD_LAT; k++) begin
      trk_busy = trk_busy | trk[k].vld;
    end
  end

  always_comb begin
    rvalid_nxt = '0;
    if (trk_out.vld) begin
      rvalid_nxt[trk_out.id] = 1'b1;
    end
  end

  // Return stage: rdata holds its last value between returns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rvalid <= '0;
      bus.rdata  <= '0;
    end else begin
      bus.rvalid <= rvalid_nxt;
      if (trk_out.vld) begin
        bus.rdata <= bus.mem_rdata;
      end
    end
  end

  assign bus.idle = ~bus.mem_en & ~trk_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: self-checking bench for mem_port_arbiter with a behavioural memory and a read-return scoreboard.
// Latency: checks gnt in the grant cycle, memory port one cycle later, returns 2+RD_LAT cycles after grant.
// Backpressure: per-core op queues hold req until the reference arbiter predicts a grant.
module tb_mem_port_arbiter;

  localparam int N    = 4;
  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int LAT  = 1;
  localparam int LAT3 = 3;

  logic clk = 1'b0;
  logic reset;
  logic mem_clr;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) bus ();
  mem_port_arbiter_if #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) bus3 ();

  mem_port_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  mem_port_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT3)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3)
  );

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return (a == 16'h0040) ? 16'hBEEF : (a ^ 16'hA5C3);
  endfunction

  // Behavioural single-port memory, RD_LAT = LAT, 256 words.
  logic [DW-1:0] mem_arr [256];
  logic [255:0]  mem_wr;
  logic [DW-1:0] rd_pipe [LAT];

  always @(posedge clk) begin
    if (mem_clr) begin
      mem_wr <= '0;
    end else if (bus.mem_en && bus.mem_wren) begin
      mem_arr[bus.mem_addr[7:0]] <= bus.mem_wdata;
      mem_wr[bus.mem_addr[7:0]]  <= 1'b1;
    end
    if (bus.mem_en && !bus.mem_wren) begin
      rd_pipe[0] <= mem_wr[bus.mem_addr[7:0]] ? mem_arr[bus.mem_addr[7:0]] : init_val(bus.mem_addr);
    end
    for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign bus.mem_rdata = rd_pipe[LAT-1];

  // Read-only memory for the RD_LAT=3 instance: data = addr ^ 0x5A5A after 3 cycles.
  logic [DW-1:0] p3 [LAT3];
  always @(posedge clk) begin
    p3[0] <= bus3.mem_addr ^ 16'h5A5A;
    for (int k = 1; k < LAT3; k++) p3[k] <= p3[k-1];
  end
  assign bus3.mem_rdata = p3[LAT3-1];

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } op_t;

  typedef struct {
    int            due;
    int            core;
    logic [DW-1:0] data;
  } exp_t;

  op_t  cq [N][$];
  exp_t sb [$];

  logic [DW-1:0] ref_arr [256];
  logic [255:0]  ref_wr;

  int            m_ptr;
  logic          e_en, e_wren;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_rdata;
  int            cyc;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", tag, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_wr[a[7:0]] ? ref_arr[a[7:0]] : init_val(a);
  endfunction

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (cq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push_op(input int core, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    op_t op;
    op.we = we; op.addr = a; op.wdata = d;
    cq[core].push_back(op);
  endtask

  // One cycle: entered and left #1 after a rising edge.
  task automatic step();
    int            g;
    int            c;
    logic [N-1:0]  exp_g;
    logic [N-1:0]  exp_rv;
    exp_t          e;
    op_t           op;
    for (int i = 0; i < N; i++) begin
      if (cq[i].size() > 0) begin
        bus.req[i] = 1'b1;
        bus.we[i]  = cq[i][0].we;
        bus.addr[i*AW +: AW]  = cq[i][0].addr;
        bus.wdata[i*DW +: DW] = cq[i][0].wdata;
      end else begin
        bus.req[i] = 1'b0;
        bus.we[i]  = 1'b0;
      end
    end
    @(negedge clk);
    g = -1;
    for (int k = 0; k < N; k++) begin
      c = (m_ptr + k) % N;
      if (g < 0 && cq[c].size() > 0) g = c;
    end
    exp_g = '0;
    if (g >= 0) exp_g[g] = 1'b1;
    check("gnt", 32'(bus.gnt), 32'(exp_g));
    check("mem_en", 32'(bus.mem_en), 32'(e_en));
    check("mem_wren", 32'(bus.mem_wren), 32'(e_wren));
    check("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
    check("mem_wdata", 32'(bus.mem_wdata), 32'(e_wdata));
    exp_rv = '0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      exp_rv[e.core] = 1'b1;
      e_rdata = e.data;
    end
    check("rvalid", 32'(bus.rvalid), 32'(exp_rv));
    check("rdata", 32'(bus.rdata), 32'(e_rdata));
    check("idle", 32'(bus.idle), 32'(!e_en && sb.size() == 0));
    e_en = 1'b0;
    e_wren = 1'b0;
    if (g >= 0) begin
      op = cq[g].pop_front();
      e_en = 1'b1;
      e_wren = op.we;
      e_addr = op.addr;
      if (op.we) begin
        e_wdata = op.wdata;
        ref_arr[op.addr[7:0]] = op.wdata;
        ref_wr[op.addr[7:0]]  = 1'b1;
      end else begin
        e.due = cyc + 2 + LAT;
        e.core = g;
        e.data = ref_rd(op.addr);
        sb.push_back(e);
      end
      m_ptr = (g + 1) % N;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    int budget;
    budget = 300;
    while ((pending() || sb.size() > 0 || e_en) && budget > 0) begin
      step();
      budget--;
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    bus.req = '1;
    #1;
    check("rst_gnt", 32'(bus.gnt), 32'h0);
    check("rst_gnt3", 32'(bus3.gnt), 32'h0);
    check("rst_mem_en", 32'(bus.mem_en), 32'h0);
    check("rst_mem_wren", 32'(bus.mem_wren), 32'h0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'h0);
    check("rst_rvalid", 32'(bus.rvalid), 32'h0);
    check("rst_rdata", 32'(bus.rdata), 32'h0);
    check("rst_idle", 32'(bus.idle), 32'h1);
    m_ptr = 0;
    e_en = 1'b0; e_wren = 1'b0; e_addr = '0; e_wdata = '0; e_rdata = '0;
    sb.delete();
    for (int i = 0; i < N; i++) cq[i].delete();
    repeat (cycles) @(posedge clk);
    #1;
    bus.req = '0;
    reset = 1'b0;
    cyc = cyc + cycles;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t rop;
    reset = 1'b1;
    mem_clr = 1'b1;
    bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
    bus3.req = '0; bus3.we = '0; bus3.addr = '0; bus3.wdata = '0;
    ref_wr = '0;
    cyc = 0;
    @(posedge clk);
    #1;
    do_reset(3);
    mem_clr = 1'b0;

    // Single read from core 2 of 0x0040 (holds 0xBEEF).
    step(); step();
    push_op(2, 1'b0, 16'h0040, '0);
    drain();

    // All cores requesting continuously from reset: 0,1,2,3,0,...
    do_reset(2);
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < N; i++) push_op(i, 1'b0, 16'(16'h0020 + i*4 + j), '0);
    drain();

    // Pointer wrap after a grant to core 3: core 0 then core 3.
    push_op(3, 1'b0, 16'h0041, '0);
    push_op(0, 1'b0, 16'h0040, '0);
    drain();

    // Write then read through another core.
    push_op(1, 1'b1, 16'h0010, 16'h1234);
    step();
    push_op(0, 1'b0, 16'h0010, '0);
    drain();

    // Read then write to the same address in consecutive grants, then read back.
    push_op(2, 1'b0, 16'h0010, '0);
    push_op(3, 1'b1, 16'h0010, 16'h5555);
    push_op(0, 1'b0, 16'h0010, '0);
    drain();

    // Random mixed traffic on a small address range.
    for (int t = 0; t < 80; t++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 2) == 0 && cq[i].size() < 3) begin
          rop.we    = 1'($urandom_range(0, 1));
          rop.addr  = 16'($urandom_range(0, 15));
          rop.wdata = 16'($urandom);
          cq[i].push_back(rop);
        end
      end
      step();
    end
    drain();

    // Reset one cycle after a read grant: the read must never return.
    push_op(2, 1'b0, 16'h0003, '0);
    step();
    check("pre_rst_mem_en", 32'(bus.mem_en), 32'h1);
    do_reset(2);
    repeat (6) step();
    push_op(3, 1'b0, 16'h0004, '0);
    push_op(1, 1'b0, 16'h0005, '0);
    drain();

    // RD_LAT=3 instance: grant at t, rvalid at t+5.
    bus3.req[0] = 1'b1;
    bus3.we[0]  = 1'b0;
    bus3.addr[AW-1:0] = 16'h0123;
    @(negedge clk);
    check("l3_gnt", 32'(bus3.gnt), 32'h1);
    @(posedge clk);
    #1;
    bus3.req[0] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("l3_rvalid", 32'(bus3.rvalid), (k == 5) ? 32'h1 : 32'h0);
      if (k == 5) check("l3_rdata", 32'(bus3.rdata), 32'h5B79);
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
